pcs_tx_frame_gen: RTL and testbench

// Frame source driving the pcs_tx client interface (ctrl/idle/start/term/err/keep/data, ready

---
 rtl/pcs_tx_frame_gen.sv | 167 ++++++++++++++++
 tb/tb_pcs_tx_frame_gen.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pcs_tx_frame_gen.sv
// rtl/pcs_tx_frame_gen.sv - Ethernet test frame source driving the pcs_tx client interface
// Back-to-back frames, programmable payload length and gap, incrementing byte pattern.
module pcs_tx_frame_gen #(
  parameter int IS_10G = 1,
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int LEN_W  = 16,
  parameter int IPG_W  = 8
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        en_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic [IPG_W-1:0]            ipg_i,
  input  logic                        ready_i,
  output logic                        ctrl_v_o,
  output logic                        idle_v_o,
  output logic [(IS_10G ? 2 : 1)-1:0] start_v_o,
  output logic                        term_v_o,
  output logic                        err_v_o,
  output logic [KEEP_W-1:0]           keep_o,
  output logic [DATA_W-1:0]           data_o,
  output logic [31:0]                 frame_cnt_o,
  output logic                        busy_o
);

  localparam int SW = IS_10G ? 2 : 1;
  localparam int NW = LEN_W - 3;
  localparam logic [DATA_W-1:0] PREAMBLE = DATA_W'(64'hD555_5555_5555_5555);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_TERM  = 3'd3;
  localparam logic [2:0] S_IPG   = 3'd4;

  logic [2:0]        state, state_n;
  logic [NW-1:0]     beats_left, beats_n;
  logic [2:0]        rem, rem_n;
  logic [7:0]        next_byte, byte_n;
  logic [IPG_W-1:0]  gap_cnt, gap_n;
  logic [31:0]       cnt_n;
  logic              start_q;
  logic              do_start, do_data, do_term;
  logic [LEN_W-1:0]  len_eff;
  logic [IPG_W-1:0]  gap_eff;
  logic              ctrl_n, idle_n, start_n, term_n;
  logic [KEEP_W-1:0] keep_n;
  logic [DATA_W-1:0] data_n;

  // Low nb bytes carry base, base+1, ...; upper bytes are zero.
  function automatic logic [DATA_W-1:0] pattern(input logic [7:0] base, input logic [3:0] nb);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < KEEP_W; i++)
      if (i < int'(nb)) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  function automatic logic [KEEP_W-1:0] keep_mask(input logic [3:0] nb);
    logic [KEEP_W-1:0] k;
    for (int i = 0; i < KEEP_W; i++)
      k[i] = (i < int'(nb));
    return k;
  endfunction

  assign len_eff = (len_i < LEN_W'(8)) ? LEN_W'(8) : len_i;
  assign gap_eff = (ipg_i == '0) ? IPG_W'(1) : ipg_i;

  always_comb begin
    state_n  = state;
    beats_n  = beats_left;
    rem_n    = rem;
    byte_n   = next_byte;
    gap_n    = gap_cnt;
    cnt_n    = frame_cnt_o;
    do_start = 1'b0;
    do_data  = 1'b0;
    do_term  = 1'b0;
    case (state)
      S_IDLE:  if (en_i) do_start = 1'b1;
      S_START, S_DATA: begin
        if (beats_left != '0) do_data = 1'b1;
        else                  do_term = 1'b1;
      end
      S_TERM: begin
        gap_n   = gap_eff - IPG_W'(1);
        state_n = S_IPG;
      end
      S_IPG: begin
        if (gap_cnt != '0) gap_n = gap_cnt - IPG_W'(1);
        else if (en_i)     do_start = 1'b1;
        else               state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    ctrl_n  = 1'b1;
    idle_n  = 1'b1;
    start_n = 1'b0;
    term_n  = 1'b0;
    keep_n  = '0;
    data_n  = '0;
    if (do_start) begin
      state_n = S_START;
      beats_n = len_eff[LEN_W-1:3];
      rem_n   = len_eff[2:0];
      byte_n  = frame_cnt_o[7:0];
      idle_n  = 1'b0;
      start_n = 1'b1;
      keep_n  = '1;
      data_n  = PREAMBLE;
    end else if (do_data) begin
      state_n = S_DATA;
      beats_n = beats_left - NW'(1);
      byte_n  = next_byte + 8'(KEEP_W);
      ctrl_n  = 1'b0;
      idle_n  = 1'b0;
      keep_n  = '1;
      data_n  = pattern(next_byte, 4'(KEEP_W));
    end else if (do_term) begin
      state_n = S_TERM;
      cnt_n   = frame_cnt_o + 32'd1;
      idle_n  = 1'b0;
      term_n  = 1'b1;
      keep_n  = keep_mask({1'b0, rem});
      data_n  = pattern(next_byte, {1'b0, rem});
    end
  end

  // Everything advances together and only on ready_i, so a stall freezes the beat on the bus.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      beats_left  <= '0;
      rem         <= '0;
      next_byte   <= '0;
      gap_cnt     <= '0;
      frame_cnt_o <= '0;
      ctrl_v_o    <= 1'b1;
      idle_v_o    <= 1'b1;
      start_q     <= 1'b0;
      term_v_o    <= 1'b0;
      keep_o      <= '0;
      data_o      <= '0;
      busy_o      <= 1'b0;
    end else if (ready_i) begin
      state       <= state_n;
      beats_left  <= beats_n;
      rem         <= rem_n;
      next_byte   <= byte_n;
      gap_cnt     <= gap_n;
      frame_cnt_o <= cnt_n;
      ctrl_v_o    <= ctrl_n;
      idle_v_o    <= idle_n;
      start_q     <= start_n;
      term_v_o    <= term_n;
      keep_o      <= keep_n;
      data_o      <= data_n;
      busy_o      <= (state_n == S_START) || (state_n == S_DATA) || (state_n == S_TERM);
    end
  end

  assign start_v_o = SW'(start_q);
  assign err_v_o   = 1'b0;

endmodule

// File: tb/tb_pcs_tx_frame_gen.sv
// tb/tb_pcs_tx_frame_gen.sv - directed bench for pcs_tx_frame_gen
// Beats are checked on the falling edge against hand-computed frames.
module tb_pcs_tx_frame_gen;

  localparam logic [63:0] PRE = 64'hD555_5555_5555_5555;
  localparam int K_IDLE  = 0;
  localparam int K_START = 1;
  localparam int K_DATA  = 2;
  localparam int K_TERM  = 3;

  logic        clk = 1'b0;
  logic        nreset;
  logic        en_i;
  logic [15:0] len_i;
  logic [7:0]  ipg_i;
  logic        ready_i;
  logic        ctrl_v_o, idle_v_o, term_v_o, err_v_o, busy_o;
  logic [1:0]  start_v_o;
  logic [7:0]  keep_o;
  logic [63:0] data_o;
  logic [31:0] frame_cnt_o;

  int tests = 0;
  int fails = 0;

  pcs_tx_frame_gen dut (
    .clk(clk), .nreset(nreset), .en_i(en_i), .len_i(len_i), .ipg_i(ipg_i),
    .ready_i(ready_i), .ctrl_v_o(ctrl_v_o), .idle_v_o(idle_v_o), .start_v_o(start_v_o),
    .term_v_o(term_v_o), .err_v_o(err_v_o), .keep_o(keep_o), .data_o(data_o),
    .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ctrl, idle, start[1:0], term, err, busy, keep}
  task automatic beat(input string tag, input int kind, input logic [7:0] k,
                      input logic [63:0] d, input logic b, input logic [31:0] cnt);
    logic [14:0] obs, exp;
    obs = {ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, busy_o, keep_o};
    exp = {kind != K_DATA, kind == K_IDLE, 1'b0, kind == K_START, kind == K_TERM, 1'b0, b, k};
    chk({tag, "_ctl"}, 64'(obs), 64'(exp));
    chk({tag, "_data"}, data_o, d);
    chk({tag, "_cnt"}, 64'(frame_cnt_o), 64'(cnt));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    nreset = 1'b0; en_i = 1'b0; ready_i = 1'b1; len_i = 16'd16; ipg_i = 8'd3;
    step(); step();
    beat("rst", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd0);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); beat("idle_off", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd0);
    end

    // Frame 0: len 16, ipg 3
    en_i = 1'b1;
    step(); beat("f0_start", K_START, 8'hFF, PRE, 1'b1, 32'd0);
    step(); beat("f0_d0", K_DATA, 8'hFF, 64'h0706050403020100, 1'b1, 32'd0);
    step(); beat("f0_d1", K_DATA, 8'hFF, 64'h0F0E0D0C0B0A0908, 1'b1, 32'd0);
    step(); beat("f0_term", K_TERM, 8'h00, 64'h0, 1'b1, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(); beat("f0_ipg", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd1);
    end

    // Frame 1: len change after start must not affect this frame
    step(); beat("f1_start", K_START, 8'hFF, PRE, 1'b1, 32'd1);
    len_i = 16'd13;
    step(); beat("f1_d0", K_DATA, 8'hFF, 64'h0807060504030201, 1'b1, 32'd1);
    step(); beat("f1_d1", K_DATA, 8'hFF, 64'h100F0E0D0C0B0A09, 1'b1, 32'd1);
    step(); beat("f1_term", K_TERM, 8'h00, 64'h0, 1'b1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(); beat("f1_ipg", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd2);
    end

    // Frame 2: len 13 -> partial term beat
    step(); beat("f2_start", K_START, 8'hFF, PRE, 1'b1, 32'd2);
    step(); beat("f2_d0", K_DATA, 8'hFF, 64'h0908070605040302, 1'b1, 32'd2);
    step(); beat("f2_term", K_TERM, 8'h1F, 64'h0000000E0D0C0B0A, 1'b1, 32'd3);
    len_i = 16'd3; ipg_i = 8'd0;
    step(); beat("f2_ipg", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd3);

    // Frame 3: len 3 clamps to 8, ipg 0 clamps to 1
    step(); beat("f3_start", K_START, 8'hFF, PRE, 1'b1, 32'd3);
    step(); beat("f3_d0", K_DATA, 8'hFF, 64'h0A09080706050403, 1'b1, 32'd3);
    step(); beat("f3_term", K_TERM, 8'h00, 64'h0, 1'b1, 32'd4);
    len_i = 16'd24; ipg_i = 8'd2;
    step(); beat("f3_ipg0", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd4);
    step(); beat("f3_ipg1", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd4);

    // Frame 4: stall mid-data, then drop enable
    step(); beat("f4_start", K_START, 8'hFF, PRE, 1'b1, 32'd4);
    step(); beat("f4_d0", K_DATA, 8'hFF, 64'h0B0A090807060504, 1'b1, 32'd4);
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); beat("f4_stall", K_DATA, 8'hFF, 64'h0B0A090807060504, 1'b1, 32'd4);
    end
    ready_i = 1'b1;
    step(); beat("f4_d1", K_DATA, 8'hFF, 64'h131211100F0E0D0C, 1'b1, 32'd4);
    en_i = 1'b0;
    step(); beat("f4_d2", K_DATA, 8'hFF, 64'h1B1A191817161514, 1'b1, 32'd4);
    step(); beat("f4_term", K_TERM, 8'h00, 64'h0, 1'b1, 32'd5);
    for (int i = 0; i < 5; i++) begin
      step(); beat("f4_after", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd5);
    end

    // Frame 5: reset mid-frame returns to reset values at once
    en_i = 1'b1;
    step(); beat("f5_start", K_START, 8'hFF, PRE, 1'b1, 32'd5);
    step(); beat("f5_d0", K_DATA, 8'hFF, 64'h0C0B0A0908070605, 1'b1, 32'd5);
    nreset = 1'b0;
    #1;
    beat("mid_rst", K_IDLE, 8'h00, 64'h0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
